spio_uart_rx_ctrl: RTL
======================

// Module: spio_uart_rx_ctrl
// PURPOSE
//  UART receive controller: oversamples the asynchronous RX line through an internal
//  spio_uart_sync instance, detects and qualifies start bits, samples each bit
//  mid-period and presents whole bytes on a valid/ready stream.
//  Sits between the board RX pin and the spio UART-to-packet bridge.
//  Shares a baud-tick generator with the TX side.
// PARAMETERS
//  NUM_SYNC_STAGES  2   synchroniser depth passed to spio_uart_sync (>=1)
//  OVERSAMPLE       16  BAUD_TICK_IN pulses per bit period (even, >=4)
//  DATA_BITS        8   data bits per frame, LSB first (5..8)
//  PARITY_ODD       0   1=odd, 0=even parity (used only with SPIO_UART_RX_PARITY_EN)
// PORTS
//  CLK_IN          in   1          system clock
//  RESET_IN        in   1          asynchronous active-high reset
//  RX_IN           in   1          raw asynchronous UART line; idle high
//  BAUD_TICK_IN    in   1          1-cycle pulse, OVERSAMPLE per bit period
//  DATA_OUT        out  DATA_BITS  received byte
//  VLD_OUT         out  1          DATA_OUT valid
//  RDY_IN          in   1          consumer accepts when VLD_OUT&&RDY_IN
//  FRAMING_ERR_OUT out  1          1-cycle pulse: stop bit sampled low
//  PARITY_ERR_OUT  out  1          1-cycle pulse: parity mismatch
//  OVERFLOW_OUT    out  1          1-cycle pulse: byte dropped, output reg full
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): FSM->IDLE, counters 0, DATA_OUT=0,
//    VLD_OUT=0, all *_ERR/OVERFLOW=0; synchroniser flops init to 1 (idle line).
//  - All FSM/counter updates only on cycles with BAUD_TICK_IN=1, except the output
//    handshake, which acts every cycle.
//  - rx_s = synchronised RX. Tick counter tc counts 0..OVERSAMPLE-1.
//  - IDLE: rx_s==0 on a tick -> START, tc=0.
//  - START: at tc==OVERSAMPLE/2-1 (mid start bit): rx_s==1 -> IDLE (glitch, no flag);
//    else tc=0, bit index=0 -> DATA.
//  - DATA: at tc==OVERSAMPLE-1 sample rx_s into shift reg (LSB first), tc=0;
//    after DATA_BITS samples -> PARITY (macro) or STOP.
//  - STOP: at tc==OVERSAMPLE-1 sample. rx_s==1 -> commit byte, -> IDLE.
//    rx_s==0 -> FRAMING_ERR_OUT pulse, byte discarded, -> BREAK.
//  - BREAK: stay until rx_s==1 on a tick, then IDLE (a held-low line gives one error only).
//  - Commit: output reg empty (VLD_OUT=0, or VLD_OUT&&RDY_IN this cycle) -> DATA_OUT
//    loaded, VLD_OUT=1 the next cycle. Latency: stop mid-sample tick -> VLD_OUT +1 cycle.
//    Reg full and not accepted -> byte dropped, OVERFLOW_OUT pulse; old DATA_OUT kept.
//  - DATA_OUT stable while VLD_OUT&&!RDY_IN. Accept without new commit -> VLD_OUT=0
//    next cycle.
//  - RX activity never stalls on RDY_IN; the receive FSM keeps running.
//  - Error pulses are exactly one CLK_IN cycle. Commit and accept may coincide.
// CONFIGURATION
//  SPIO_UART_RX_PARITY_EN defined: extra PARITY state after DATA.
//    Sample at tc==OVERSAMPLE-1. Expected bit = ^data ^ PARITY_ODD.
//    Mismatch -> PARITY_ERR_OUT pulse; byte still passes through STOP, then discarded.
//    If the stop bit is also low, FRAMING_ERR_OUT pulses too.
//  Undefined: no PARITY state, frame = start+DATA_BITS+stop; PARITY_ERR_OUT tied 0.
// STRUCTURE
//  spio_uart_pkg: FSM state encoding (IDLE,START,DATA,PARITY,STOP,BREAK), tick-counter
//    width function clog2(OVERSAMPLE), default OVERSAMPLE/DATA_BITS constants
//    shared with the TX side.
//  Sub-module: spio_uart_sync (NUM_BITS=1, NUM_STAGES=NUM_SYNC_STAGES, INITIAL_VALUE=1)
//    on RX_IN.
//  Output register + handshake kept in this module; no further sub-modules.
// TESTING (defaults, tick every 4 clks, 16 ticks/bit)
//  1. Frame 0x55, RDY_IN=1 -> DATA_OUT=0x55, VLD_OUT for 1 cycle, 1 clk after stop mid-tick;
//     no error pulses.
//  2. RX low for 4 ticks then high -> no VLD_OUT, no error pulses; FSM back in IDLE.
//  3. Frame 0xA3 with stop bit low, then line held low 40 bit-times -> exactly one
//     FRAMING_ERR_OUT, no VLD_OUT. Next valid 0x0F is received after line returns high.
//  4. RDY_IN=0, frames 0xA5 then 0x3C -> DATA_OUT=0xA5 held, OVERFLOW_OUT pulses once.
//     RDY_IN=1 -> 0xA5 accepted, VLD_OUT=0.
//  5. Reset asserted mid-DATA of 0xFF -> all outputs 0 immediately. Frame 0x81 after
//     release -> 0x81 received.
//  6. (SPIO_UART_RX_PARITY_EN, even) 0x07 with parity 1 -> VLD 0x07.
//     Parity 0 -> PARITY_ERR_OUT pulse, no VLD_OUT.

Source files
------------

// File: rtl/spio_uart_pkg.sv
// Shared spio UART definitions: FSM encoding, default frame constants and
// the tick-counter width helper used by both RX and TX.
package spio_uart_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/spio_uart_sync.sv
// Multi-stage synchroniser for asynchronous inputs; reset loads
// INITIAL_VALUE so an idle line does not look like activity.
module spio_uart_sync #(
    parameter int                  NUM_BITS      = 1,
    parameter int                  NUM_STAGES    = 2,
    parameter logic [NUM_BITS-1:0] INITIAL_VALUE = '0
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic [NUM_BITS-1:0] DATA_IN,
    output logic [NUM_BITS-1:0] DATA_OUT
);

    logic [NUM_BITS-1:0] stg [NUM_STAGES];

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            for (int i = 0; i < NUM_STAGES; i++)
                stg[i] <= INITIAL_VALUE;
        end else begin
            stg[0] <= DATA_IN;
            for (int i = 1; i < NUM_STAGES; i++)
                stg[i] <= stg[i-1];
        end
    end

    assign DATA_OUT = stg[NUM_STAGES-1];

endmodule

// File: rtl/spio_uart_rx_ctrl.sv
// UART receive controller: oversampled start qualification, mid-bit sampling,
// valid/ready byte output. Define SPIO_UART_RX_PARITY_EN for a parity bit.
module spio_uart_rx_ctrl
    import spio_uart_pkg::*;
#(
    parameter int NUM_SYNC_STAGES = 2,
    parameter int OVERSAMPLE      = DEF_OVERSAMPLE,
    parameter int DATA_BITS       = DEF_DATA_BITS,
    parameter int PARITY_ODD      = 0
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_IN,
    input  logic                 RX_IN,
    input  logic                 BAUD_TICK_IN,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 VLD_OUT,
    input  logic                 RDY_IN,
    output logic                 FRAMING_ERR_OUT,
    output logic                 PARITY_ERR_OUT,
    output logic                 OVERFLOW_OUT
);

    localparam int TCW = clog2(OVERSAMPLE);
    localparam int BW  = clog2(DATA_BITS);
    localparam logic [TCW-1:0] TC_MID = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_END = TCW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BI_END = BW'(DATA_BITS - 1);
    localparam logic           PAR_ODD = (PARITY_ODD != 0);

`ifdef SPIO_UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_t AFTER_DATA = ST_STOP;
`endif

    rx_state_t            state;
    logic [TCW-1:0]       tc;
    logic [BW-1:0]        bidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 rx_s;
    logic                 out_free;

    spio_uart_sync #(
        .NUM_BITS      (1),
        .NUM_STAGES    (NUM_SYNC_STAGES),
        .INITIAL_VALUE (1'b1)
    ) u_sync (
        .CLK_IN   (CLK_IN),
        .RESET_IN (RESET_IN),
        .DATA_IN  (RX_IN),
        .DATA_OUT (rx_s)
    );

    assign out_free = !VLD_OUT || RDY_IN;

`ifndef SPIO_UART_RX_PARITY_EN
    assign PARITY_ERR_OUT = 1'b0;
    assign par_bad        = 1'b0 & PAR_ODD;
`endif

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state           <= ST_IDLE;
            tc              <= '0;
            bidx            <= '0;
            shreg           <= '0;
            DATA_OUT        <= '0;
            VLD_OUT         <= 1'b0;
            FRAMING_ERR_OUT <= 1'b0;
            OVERFLOW_OUT    <= 1'b0;
`ifdef SPIO_UART_RX_PARITY_EN
            par_bad         <= 1'b0;
            PARITY_ERR_OUT  <= 1'b0;
`endif
        end else begin
            FRAMING_ERR_OUT <= 1'b0;
            OVERFLOW_OUT    <= 1'b0;
`ifdef SPIO_UART_RX_PARITY_EN
            PARITY_ERR_OUT  <= 1'b0;
`endif
            if (VLD_OUT && RDY_IN)
                VLD_OUT <= 1'b0;
            if (BAUD_TICK_IN) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state <= ST_START;
                            tc    <= '0;
                        end
                    end
                    ST_START: begin
                        if (tc == TC_MID) begin
                            if (rx_s) begin
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DATA;
                                tc    <= '0;
                                bidx  <= '0;
`ifdef SPIO_UART_RX_PARITY_EN
                                par_bad <= 1'b0;
`endif
                            end
                        end else begin
                            tc <= tc + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (tc == TC_END) begin
                            tc    <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            bidx  <= bidx + 1'b1;
                            if (bidx == BI_END)
                                state <= AFTER_DATA;
                        end else begin
                            tc <= tc + 1'b1;
                        end
                    end
`ifdef SPIO_UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (tc == TC_END) begin
                            tc    <= '0;
                            state <= ST_STOP;
                            if (rx_s != (^shreg ^ PAR_ODD)) begin
                                par_bad        <= 1'b1;
                                PARITY_ERR_OUT <= 1'b1;
                            end
                        end else begin
                            tc <= tc + 1'b1;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (tc == TC_END) begin
                            tc <= '0;
                            if (!rx_s) begin
                                FRAMING_ERR_OUT <= 1'b1;
                                state           <= ST_BREAK;
                            end else begin
                                state <= ST_IDLE;
                                if (!par_bad) begin
                                    if (out_free) begin
                                        DATA_OUT <= shreg;
                                        VLD_OUT  <= 1'b1;
                                    end else begin
                                        OVERFLOW_OUT <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            tc <= tc + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
